// File: rtl/u_mod_counter_pkg.sv
// Shared definitions for the modulo up/down counter family.
//   PRIME_MASK : 256-bit lookup, bit n is set when n is prime.
//   UP/DOWN    : encodings of the upb direction input.
//   SAT/WRAP   : encodings of the satb limit-mode input.
package u_mod_counter_pkg;

    // Built by trial division at elaboration rather than written out as a
    // hex literal, so the table cannot drift from its definition.
    function automatic logic [255:0] gen_prime_mask();
        logic [255:0] m;
        m = '0;
        for (int unsigned n = 2; n < 256; n++) begin
            logic is_p;
            is_p = 1'b1;
            for (int unsigned k = 2; k * k <= n; k++) begin
                if (n % k == 0) is_p = 1'b0;
            end
            m[n] = is_p;
        end
        return m;
    endfunction

    localparam logic [255:0] PRIME_MASK = gen_prime_mask();

    localparam logic UP   = 1'b0;
    localparam logic DOWN = 1'b1;
    localparam logic SAT  = 1'b0;
    localparam logic WRAP = 1'b1;

endpackage

// File: rtl/u_mod_counter_if.sv
// Control/status bundle of one counter instance.
//   master : drives clrb, ldb, hdb, upb, satb, cib, d; observes q, pn, tcb, ovf.
//   slave  : the counter side of the same signals.
interface u_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             clrb;
    logic             ldb;
    logic             hdb;
    logic             upb;
    logic             satb;
    logic             cib;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             pn;
    logic             tcb;
    logic             ovf;

    modport master (
        output clrb, ldb, hdb, upb, satb, cib, d,
        input  q, pn, tcb, ovf
    );

    modport slave (
        input  clrb, ldb, hdb, upb, satb, cib, d,
        output q, pn, tcb, ovf
    );
endinterface

// File: rtl/u_prime_detect.sv
// Primality flag for a WIDTH-bit value via PRIME_MASK lookup.
//   q  : value under test (WIDTH bits, WIDTH <= 8).
//   pn : 1 when q is prime.
module u_prime_detect
    import u_mod_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    output logic             pn
);

    logic [7:0] idx;

    always_comb begin
        idx            = '0;
        idx[WIDTH-1:0] = q;
        pn             = PRIME_MASK[idx];
    end

endmodule

// File: rtl/u_mod_counter.sv
// WIDTH-bit modulo-MOD up/down counter, state updates on falling clkb.
//   clkb : clock (falling edge active).
//   rstb : asynchronous active-low reset.
//   bus  : slave side of u_mod_counter_if -- active-low clear/load/hold/
//          count-enable, direction, limit mode, load value d; outputs q,
//          prime flag pn, active-low terminal count tcb, sticky ovf.
module u_mod_counter
    import u_mod_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 16
) (
    input  logic            clkb,
    input  logic            rstb,
    u_mod_counter_if.slave  bus
);

    if (WIDTH < 2 || WIDTH > 8) begin : g_bad_width
        $error("u_mod_counter: WIDTH must be 2..8");
    end
    if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
        $error("u_mod_counter: MOD must be 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] cnt_d, cnt_q;
    logic             ovf_d, ovf_q;
    logic             at_limit;

    always_comb begin
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        at_limit = (bus.upb == UP) ? (cnt_q == MAX) : (cnt_q == '0);

        if (!bus.clrb) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (!bus.ldb) begin
            cnt_d = (bus.d > MAX) ? MAX : bus.d;
            ovf_d = 1'b0;
        end else if (bus.hdb && !bus.cib) begin
            if (at_limit) begin
                // Limit reached: wrap to the opposite end or stay put.
                ovf_d = 1'b1;
                if (bus.satb == WRAP) cnt_d = (bus.upb == UP) ? '0 : MAX;
            end else begin
                cnt_d = (bus.upb == UP) ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
            end
        end
    end

    always_ff @(negedge clkb or negedge rstb) begin
        if (!rstb) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Asserted in both wrap and saturate modes so a cascaded stage still
    // sees the limit.
    assign bus.tcb = !(bus.clrb && bus.ldb && bus.hdb && !bus.cib && at_limit);
    assign bus.q   = cnt_q;
    assign bus.ovf = ovf_q;

    u_prime_detect #(.WIDTH(WIDTH)) u_pd (
        .q  (cnt_q),
        .pn (bus.pn)
    );

endmodule

// File: tb/tb_u_mod_counter.sv
module tb_u_mod_counter;

    logic clkb;
    logic rstb;
    int   checks;
    int   errors;

    u_mod_counter_if #(.WIDTH(4)) a_if ();
    u_mod_counter_if #(.WIDTH(4)) lo_if ();
    u_mod_counter_if #(.WIDTH(4)) hi_if ();
    u_mod_counter_if #(.WIDTH(8)) w_if ();

    u_mod_counter #(.WIDTH(4), .MOD(10)) dut_a (
        .clkb (clkb), .rstb (rstb), .bus (a_if.slave)
    );
    u_mod_counter #(.WIDTH(4), .MOD(10)) dut_lo (
        .clkb (clkb), .rstb (rstb), .bus (lo_if.slave)
    );
    u_mod_counter #(.WIDTH(4), .MOD(10)) dut_hi (
        .clkb (clkb), .rstb (rstb), .bus (hi_if.slave)
    );
    u_mod_counter #(.WIDTH(8), .MOD(256)) dut_w (
        .clkb (clkb), .rstb (rstb), .bus (w_if.slave)
    );

    // cascade: high stage enabled by low stage terminal count
    assign hi_if.cib = lo_if.tcb;

    initial clkb = 1'b1;
    always #5 clkb = ~clkb;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic       clrb;
        logic       ldb;
        logic       hdb;
        logic       upb;
        logic       satb;
        logic       cib;
        logic [3:0] d;
        logic [3:0] q;
        logic       pn;
        logic       tcb;
        logic       ovf;
    } vec_t;

    vec_t vecs [25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic edge_wait();
        @(negedge clkb);
        #1;
    endtask

    task automatic drive_a(input vec_t v);
        a_if.clrb = v.clrb; a_if.ldb = v.ldb; a_if.hdb = v.hdb;
        a_if.upb  = v.upb;  a_if.satb = v.satb; a_if.cib = v.cib;
        a_if.d    = v.d;
    endtask

    initial begin
        int unsigned wexp_q [6];
        int unsigned wexp_pn [6];
        checks = 0;
        errors = 0;

        // clr ld hd up sat ci d | q pn tcb ovf
        vecs[0]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,4'd5,  4'd5,1'b1,1'b1,1'b0}; // load 5
        vecs[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,4'd0,  4'd5,1'b1,1'b1,1'b0}; // hold
        vecs[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,4'd0,  4'd5,1'b1,1'b1,1'b0}; // hold
        vecs[3]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,4'd7,  4'd7,1'b1,1'b1,1'b0}; // load 7
        vecs[4]  = '{1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,4'd0,  4'd8,1'b0,1'b1,1'b0}; // up wrap
        vecs[5]  = '{1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,4'd0,  4'd9,1'b0,1'b0,1'b0};
        vecs[6]  = '{1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,4'd0,  4'd0,1'b0,1'b1,1'b1};
        vecs[7]  = '{1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,4'd0,  4'd1,1'b0,1'b1,1'b1};
        vecs[8]  = '{1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,4'd0,  4'd0,1'b0,1'b1,1'b0}; // clear
        vecs[9]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,4'd2,  4'd2,1'b1,1'b1,1'b0}; // load 2
        vecs[10] = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,4'd0,  4'd1,1'b0,1'b1,1'b0}; // down sat
        vecs[11] = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,4'd0,  4'd0,1'b0,1'b0,1'b0};
        vecs[12] = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,4'd0,  4'd0,1'b0,1'b0,1'b1};
        vecs[13] = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,4'd0,  4'd0,1'b0,1'b0,1'b1};
        vecs[14] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,4'd0,  4'd9,1'b0,1'b1,1'b1}; // down wrap
        vecs[15] = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,4'd12, 4'd9,1'b0,1'b1,1'b0}; // load clamp
        vecs[16] = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,4'd3,  4'd0,1'b0,1'b1,1'b0}; // clr beats ld
        vecs[17] = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,4'd3,  4'd3,1'b1,1'b1,1'b0}; // load 3
        vecs[18] = '{1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,4'd0,  4'd3,1'b1,1'b1,1'b0}; // cib off
        vecs[19] = '{1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,4'd0,  4'd3,1'b1,1'b1,1'b0};
        vecs[20] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,4'd8,  4'd8,1'b0,1'b1,1'b0}; // load 8
        vecs[21] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,4'd0,  4'd9,1'b0,1'b0,1'b0}; // up sat
        vecs[22] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,4'd0,  4'd9,1'b0,1'b0,1'b1};
        vecs[23] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,4'd0,  4'd8,1'b0,1'b1,1'b1}; // away, ovf sticks
        vecs[24] = '{1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,4'd0,  4'd8,1'b0,1'b1,1'b1}; // hold

        wexp_q  = '{251, 252, 253, 254, 255, 0};
        wexp_pn = '{1, 0, 0, 0, 0, 0};

        // idle everything, reset asserted at time 0
        rstb = 1'b0;
        drive_a('{1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,4'd0,4'd0,1'b0,1'b0,1'b0});
        lo_if.clrb = 1'b1; lo_if.ldb = 1'b1; lo_if.hdb = 1'b1;
        lo_if.upb = 1'b0; lo_if.satb = 1'b1; lo_if.cib = 1'b1; lo_if.d = '0;
        hi_if.clrb = 1'b1; hi_if.ldb = 1'b1; hi_if.hdb = 1'b1;
        hi_if.upb = 1'b0; hi_if.satb = 1'b1; hi_if.d = '0;
        w_if.clrb = 1'b1; w_if.ldb = 1'b1; w_if.hdb = 1'b1;
        w_if.upb = 1'b0; w_if.satb = 1'b1; w_if.cib = 1'b1; w_if.d = '0;
        #3;
        chk("reset_a_q",   32'(a_if.q), 0);
        chk("reset_a_ovf", 32'(a_if.ovf), 0);
        chk("reset_a_pn",  32'(a_if.pn), 0);
        chk("reset_w_q",   32'(w_if.q), 0);
        #1 rstb = 1'b1;

        // table-driven main function checks
        for (int i = 0; i < 25; i++) begin
            drive_a(vecs[i]);
            edge_wait();
            chk($sformatf("vec%0d_q", i),   32'(a_if.q),   32'(vecs[i].q));
            chk($sformatf("vec%0d_pn", i),  32'(a_if.pn),  32'(vecs[i].pn));
            chk($sformatf("vec%0d_tcb", i), 32'(a_if.tcb), 32'(vecs[i].tcb));
            chk($sformatf("vec%0d_ovf", i), 32'(a_if.ovf), 32'(vecs[i].ovf));
        end

        // async reset mid-cycle with a load pending: q=8, ovf=1 beforehand
        drive_a('{1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,4'd7,4'd0,1'b0,1'b0,1'b0});
        #2 rstb = 1'b0;
        #1;
        chk("rst_pulse_q",   32'(a_if.q), 0);
        chk("rst_pulse_ovf", 32'(a_if.ovf), 0);
        rstb = 1'b1;
        edge_wait();
        chk("load_after_rst_q", 32'(a_if.q), 7);
        chk("load_after_rst_pn", 32'(a_if.pn), 1);

        // cascade: low stage counts up, high stage advances on low terminal count
        lo_if.cib = 1'b0;
        for (int n = 1; n <= 25; n++) begin
            edge_wait();
            chk($sformatf("casc%0d_lo", n), 32'(lo_if.q), 32'(n % 10));
            chk($sformatf("casc%0d_hi", n), 32'(hi_if.q), 32'(n / 10));
        end
        lo_if.cib = 1'b1;

        // 8-bit full-range wrap from 250
        w_if.ldb = 1'b0; w_if.d = 8'd250;
        edge_wait();
        chk("w_load_q",  32'(w_if.q), 250);
        chk("w_load_pn", 32'(w_if.pn), 0);
        w_if.ldb = 1'b1; w_if.cib = 1'b0;
        for (int i = 0; i < 6; i++) begin
            edge_wait();
            chk($sformatf("w%0d_q", i),  32'(w_if.q),  32'(wexp_q[i]));
            chk($sformatf("w%0d_pn", i), 32'(w_if.pn), 32'(wexp_pn[i]));
            chk($sformatf("w%0d_ovf", i), 32'(w_if.ovf), (i == 5) ? 32'd1 : 32'd0);
            if (i == 4) chk("w255_tcb", 32'(w_if.tcb), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/u_mod_counter.md
Name: u_mod_counter

Overview:
- Parametrised successor of the team's 4-bit up/down binary counter: WIDTH-bit modulo-MOD up/down counter.
- Keeps the same active-low control set (clear, load, hold, up/down) and the prime-number flag.
- Adds selectable wrap/saturate mode, an active-low count enable for cascading, an active-low terminal-count output and a sticky overflow flag.
- Used as a general event/timebase counter; instances chain via tcb -> cib.

Parameters:
- WIDTH, 4, counter width in bits (2..8).
- MOD, 16, count modulus; legal range 2..2^WIDTH; q spans 0..MOD-1. Out-of-range MOD is an elaboration error.

Ports:
- clkb  in  1  clock; all state updates on the falling edge.
- rstb  in  1  reset; asynchronous, active-low.
- clrb  in  1  synchronous clear, active-low.
- ldb   in  1  synchronous load of d, active-low.
- hdb   in  1  hold, active-low.
- upb   in  1  direction: 0 = count up, 1 = count down.
- satb  in  1  limit mode: 0 = saturate at limit, 1 = wrap.
- cib   in  1  count enable / cascade carry-in, active-low.
- d     in  WIDTH  load value.
- q     out WIDTH  counter value (registered).
- pn    out 1  1 when q is prime (combinational from q).
- tcb   out 1  terminal count, active-low (combinational).
- ovf   out 1  sticky limit-hit flag (registered).

Behaviour:
- Reset: rstb=0 forces q=0 and ovf=0 immediately, independent of clkb. Reset asserted mid-operation aborts any pending load or count. On release, the first falling edge applies normal rules.
- Next-state priority, evaluated at each falling clkb edge:
  - clrb=0: q=0, ovf=0.
  - else ldb=0: q=min(d, MOD-1), ovf=0. A load above MOD-1 clamps to MOD-1; ovf stays 0.
  - else hdb=0: q unchanged, ovf unchanged (cib ignored).
  - else cib=1: q unchanged.
  - else upb=0 (up):
    - q<MOD-1: q+1.
    - q=MOD-1: q=0 if satb=1, q=MOD-1 if satb=0; ovf set to 1 in both cases.
  - else (down):
    - q>0: q-1.
    - q=0: q=MOD-1 if satb=1, q=0 if satb=0; ovf set to 1 in both cases.
- Simultaneous controls resolve strictly by the priority above, e.g. clrb=0 with ldb=0 yields 0.
- Latency: one falling edge from control to q; pn and tcb follow q combinationally.
- Arithmetic: all increments and decrements are WIDTH bits wide; the MOD-1 compare replaces natural rollover. For MOD=2^WIDTH with satb=1, behaviour equals plain binary wrap.
- tcb=0 when all of the following hold:
  - hdb=1, cib=0, clrb=1, ldb=1, and
  - either (upb=0 and q=MOD-1) or (upb=1 and q=0).
  - Otherwise tcb=1.
- tcb asserts in saturate mode too, so a downstream stage still sees the limit.
- pn=1 for q in {2,3,5,7,11,13,17,...} up to 2^WIDTH-1; 0 and 1 are not prime. The flag is computed from q only, independent of MOD.
- ovf stays at 1 until cleared by clrb or ldb; counting away from the limit does not clear it.

Decomposition:
- Shared package: PRIME_MASK constant (256-bit, bit n = n is prime), direction encodings UP=1'b0 / DOWN=1'b1, mode encodings SAT=1'b0 / WRAP=1'b1.
- One sub-module: u_prime_detect #(WIDTH) (q -> pn), a PRIME_MASK lookup, reusable by other counters.
- Next-state logic and output decode live in u_mod_counter.

Test Plan:
- WIDTH=4, MOD=10. rstb pulse low at t=5 with q=7 -> q=0, ovf=0 before the next clkb fall. ldb=0, d=5 -> q=5, pn=1. Then hdb=0 for 2 edges -> q stays 5.
- MOD=10, satb=1, upb=0, cib=0 from q=7 -> 8, 9 (tcb=0, pn=0), then 0 with ovf=1, then 1. ovf remains 1 until clrb=0 -> q=0, ovf=0.
- MOD=10, satb=0, upb=1 from q=2 -> 1, 0 (tcb=0), 0, 0; ovf=1. Switch to satb=1 -> next edge q=9.
- ldb=0, d=12, MOD=10 -> q=9, ovf=0. clrb=0 and ldb=0 together with d=3 -> q=0. cib=1 with upb=0 -> q frozen and tcb=1.
- Cascade: two MOD=10 instances, low.tcb -> high.cib, up-count 25 edges from 00 -> high.q=2, low.q=5. High stage advances only on the edge where low.q=9.
- WIDTH=8, MOD=256, wrap, up from 250 -> 251 (pn=1), then 252..255, then 0 with ovf=1. pn=1 at 251 only in that window.
